dmem_arbiter: RTL and testbench

- Shares the single-port 512x32 synchronous-read data memory between two requesters.
- Port 0 is the CPU load/store unit. Port 1 is the debug/program-loader port.
- Grants at most one access per cycle, drives the RAM address/write-data/write-enable, and routes the 1-cycle-latency read data back to the owning port as a tagged response.
- Sits between the CPU datapath (LDR/STR execute) and the data memory array.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_rr_pick.sv | 60 ++++++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default geometry, port
// indices and the record kept in the one-entry response stage.
package dmem_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DATA_WORDS_DEF = 512;

  // Port indices; also used as the owner tag of a response.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // One in-flight access, captured at grant time and retired a cycle later.
  typedef struct packed {
    logic valid;    // an access was granted last cycle
    logic owner;    // PORT_CPU or PORT_DBG
    logic err;      // misaligned or out-of-range
    logic is_load;  // legal load: return RAM data, otherwise zero
  } rsp_rec_t;

  // The port that is not p.
  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way request picker. Fixed priority to the CPU port when CPU_PRIORITY
// is set, otherwise round-robin between the two ports. The pointer names the
// port preferred on a tie and only moves after a tie is resolved.
module dmem_rr_pick
  import dmem_pkg::*;
#(
  parameter int CPU_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;  // preferred port on a tie
  logic win;    // index of the granted port (meaningful when |gnt)

  // Grant at most one requester; nothing is granted while in reset.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the block leaves it unassigned and infers a latch.
    gnt = 2'b00;
    win = PORT_CPU;
    if (!reset) begin
      case (req)
        2'b01: begin
          gnt = 2'b01;
          win = PORT_CPU;
        end
        2'b10: begin
          gnt = 2'b10;
          win = PORT_DBG;
        end
        2'b11: begin
          if (CPU_PRIORITY != 0 || ptr_q == PORT_CPU) begin
            gnt = 2'b01;
            win = PORT_CPU;
          end else begin
            gnt = 2'b10;
            win = PORT_DBG;
          end
        end
        default: begin
          gnt = 2'b00;
          win = PORT_CPU;
        end
      endcase
    end
  end

  // Hand the tie preference to the loser after a contested cycle.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is updated with non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (reset) begin
      ptr_q <= PORT_CPU;
    end else if (CPU_PRIORITY == 0 && req == 2'b11) begin
      ptr_q <= other_port(win);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port synchronous-read data memory between the
// CPU load/store unit (port 0) and the debug/program-loader port (port 1).
// One access is granted per cycle; its RAM address, write data and write
// enable are driven combinationally in the grant cycle, and the response is
// returned to the owning port in the following cycle.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int DATA_WORDS   = DATA_WORDS_DEF,
  parameter int ADDR_W       = $clog2(DATA_WORDS),
  parameter int CPU_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [31:0]           p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  output logic                  p0_rsp_err,

  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [31:0]           p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                  p1_rsp_err,

  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,

  output logic                  busy
);

  // First byte address past the end of the array.
  localparam logic [31:0] ADDR_LIMIT = 32'(DATA_WORDS * 4);

  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  xfer;
  logic                  sel;
  logic                  sel_we;
  logic [31:0]           sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  legal;
  logic [ADDR_W-1:0]     word_idx;
  logic [ADDR_W-1:0]     addr_q;
  rsp_rec_t              rsp_d;
  rsp_rec_t              rsp_q;
  logic                  rsp_live;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  // ---------------------------------------------------------------- grant
  assign req = {p1_req_valid, p0_req_valid};

  dmem_rr_pick #(
    .CPU_PRIORITY (CPU_PRIORITY)
  ) u_pick (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign p0_req_ready = gnt[PORT_CPU];
  assign p1_req_ready = gnt[PORT_DBG];
  assign xfer         = |gnt;
  assign sel          = gnt[PORT_DBG] ? PORT_DBG : PORT_CPU;

  // Steer the selected port's request fields onto the shared RAM path.
  always_comb begin
    sel_we    = p0_req_we;
    sel_addr  = p0_req_addr;
    sel_wdata = p0_req_wdata;
    if (sel == PORT_DBG) begin
      sel_we    = p1_req_we;
      sel_addr  = p1_req_addr;
      sel_wdata = p1_req_wdata;
    end
  end

  // ------------------------------------------------------------- legality
  // Out-of-range addresses are flagged here, before the index is truncated,
  // so a high address never aliases onto a low word.
  assign legal    = (sel_addr[1:0] == 2'b00) && (sel_addr < ADDR_LIMIT);
  assign word_idx = sel_addr[ADDR_W+1:2];

  // ---------------------------------------------------------- RAM drive
  assign mem_addr = xfer ? word_idx : addr_q;
  assign mem_wd   = sel_wdata;
  assign mem_we   = xfer & sel_we & legal;

  // Keep the last granted word index so the RAM address is quiet when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
    end else if (xfer) begin
      addr_q <= word_idx;
    end
  end

  // ------------------------------------------------------- response stage
  // Describe the access granted this cycle for retirement next cycle.
  always_comb begin
    rsp_d         = '0;
    rsp_d.valid   = xfer;
    rsp_d.owner   = sel;
    rsp_d.err     = ~legal;
    rsp_d.is_load = ~sel_we & legal;
  end

  // One-entry response register; a pending response is dropped by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  // Reset also masks the outputs within the reset cycle itself, so a
  // response captured just before reset is never seen by either port.
  assign rsp_live  = rsp_q.valid & ~reset;
  assign rsp_rdata = rsp_q.is_load ? mem_rd : '0;

  assign p0_rsp_valid = rsp_live & (rsp_q.owner == PORT_CPU);
  assign p0_rsp_err   = p0_rsp_valid & rsp_q.err;
  assign p0_rsp_rdata = p0_rsp_valid ? rsp_rdata : '0;

  assign p1_rsp_valid = rsp_live & (rsp_q.owner == PORT_DBG);
  assign p1_rsp_err   = p1_rsp_valid & rsp_q.err;
  assign p1_rsp_rdata = p1_rsp_valid ? rsp_rdata : '0;

  assign busy = rsp_live;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. A behavioural RAM sits on the memory
// side; a reference model (word array, tie pointer, pending-response record)
// predicts every output from the access rules. A second instance with CPU
// priority enabled covers the fixed-priority mode.
module tb_dmem_arbiter;

  localparam int DW    = 32;
  localparam int WORDS = 512;
  localparam int AW    = 9;
  localparam logic [DW-1:0] FP_RD = 32'h5A5A_5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Round-robin instance
  logic          p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_err;
  logic [31:0]   p0_req_addr;
  logic [DW-1:0] p0_req_wdata, p0_rsp_rdata;
  logic          p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid, p1_rsp_err;
  logic [31:0]   p1_req_addr;
  logic [DW-1:0] p1_req_wdata, p1_rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wd, mem_rd;
  logic          busy;

  dmem_arbiter #(.DATA_WIDTH(DW), .DATA_WORDS(WORDS), .CPU_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
  );

  // Fixed-priority instance
  logic          fp_p0_req_valid, fp_p0_req_ready, fp_p0_req_we, fp_p0_rsp_valid, fp_p0_rsp_err;
  logic [31:0]   fp_p0_req_addr;
  logic [DW-1:0] fp_p0_req_wdata, fp_p0_rsp_rdata;
  logic          fp_p1_req_valid, fp_p1_req_ready, fp_p1_req_we, fp_p1_rsp_valid, fp_p1_rsp_err;
  logic [31:0]   fp_p1_req_addr;
  logic [DW-1:0] fp_p1_req_wdata, fp_p1_rsp_rdata;
  logic [AW-1:0] fp_mem_addr;
  logic          fp_mem_we;
  logic [DW-1:0] fp_mem_wd;
  logic          fp_busy;

  dmem_arbiter #(.DATA_WIDTH(DW), .DATA_WORDS(WORDS), .CPU_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset),
    .p0_req_valid(fp_p0_req_valid), .p0_req_ready(fp_p0_req_ready), .p0_req_we(fp_p0_req_we),
    .p0_req_addr(fp_p0_req_addr), .p0_req_wdata(fp_p0_req_wdata), .p0_rsp_valid(fp_p0_rsp_valid),
    .p0_rsp_rdata(fp_p0_rsp_rdata), .p0_rsp_err(fp_p0_rsp_err),
    .p1_req_valid(fp_p1_req_valid), .p1_req_ready(fp_p1_req_ready), .p1_req_we(fp_p1_req_we),
    .p1_req_addr(fp_p1_req_addr), .p1_req_wdata(fp_p1_req_wdata), .p1_rsp_valid(fp_p1_rsp_valid),
    .p1_rsp_rdata(fp_p1_rsp_rdata), .p1_rsp_err(fp_p1_rsp_err),
    .mem_addr(fp_mem_addr), .mem_we(fp_mem_we), .mem_wd(fp_mem_wd), .mem_rd(FP_RD), .busy(fp_busy)
  );

  // Behavioural read-first synchronous RAM, filled with a known pattern first.
  logic [DW-1:0] ram [WORDS];
  logic          ram_fill;

  function automatic logic [DW-1:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wd;
      mem_rd <= ram[mem_addr];
    end
  end

  // ---------------------------------------------------------- reference model
  logic [DW-1:0] model_mem [WORDS];
  bit            m_ptr;        // port preferred on a tie
  bit            pend_v;       // a response is due this cycle
  bit            pend_owner;
  bit            pend_err;
  logic [DW-1:0] pend_data;
  bit            last_known;   // an access was granted since reset
  logic [AW-1:0] last_addr;
  int            gnt_port;     // port granted in the last cycle, -1 for none

  int checks;
  int errors;

  typedef struct packed {
    logic          r0;
    logic          r1;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          v0;
    logic          e0;
    logic [DW-1:0] d0;
    logic          v1;
    logic          e1;
    logic [DW-1:0] d1;
    logic          busy;
  } view_t;

  view_t obs;
  view_t exp_v;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < WORDS * 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k < 4)       return 32'($urandom_range(0, 15)) << 2;
    else if (k < 7)  return 32'($urandom_range(0, WORDS - 1)) << 2;
    else if (k == 7) return (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
    else if (k == 8) return 32'(WORDS * 4) + (32'($urandom_range(0, 255)) << 2);
    else             return $urandom();
  endfunction

  // Drive one cycle (entered just after a rising edge), predict and sample
  // all outputs of the round-robin instance, then advance the model.
  task automatic run_cycle(input logic rst,
                           input logic v0, input logic we0, input logic [31:0] a0, input logic [DW-1:0] d0,
                           input logic v1, input logic we1, input logic [31:0] a1, input logic [DW-1:0] d1);
    int            w;
    logic          wwe;
    logic [31:0]   wa;
    logic [DW-1:0] wd;
    bit            show_addr;
    reset = rst;
    p0_req_valid = v0; p0_req_we = we0; p0_req_addr = a0; p0_req_wdata = d0;
    p1_req_valid = v1; p1_req_we = we1; p1_req_addr = a1; p1_req_wdata = d1;

    w = -1;
    if (!rst) begin
      if (v0 && v1)  w = m_ptr ? 1 : 0;
      else if (v0)   w = 0;
      else if (v1)   w = 1;
    end
    wwe = (w == 1) ? we1 : we0;
    wa  = (w == 1) ? a1  : a0;
    wd  = (w == 1) ? d1  : d0;
    show_addr = (w >= 0) || (last_known && !rst);

    exp_v    = '0;
    exp_v.r0 = (w == 0);
    exp_v.r1 = (w == 1);
    exp_v.we = (w >= 0) && wwe && legal(wa);
    if (w >= 0)         exp_v.addr = AW'(wa >> 2);
    else if (show_addr) exp_v.addr = last_addr;
    if (w >= 0)         exp_v.wd = wd;
    if (!rst && pend_v) begin
      exp_v.busy = 1'b1;
      if (!pend_owner) begin exp_v.v0 = 1'b1; exp_v.e0 = pend_err; exp_v.d0 = pend_data; end
      else             begin exp_v.v1 = 1'b1; exp_v.e1 = pend_err; exp_v.d1 = pend_data; end
    end

    @(negedge clk);
    obs      = '0;
    obs.r0   = p0_req_ready;
    obs.r1   = p1_req_ready;
    obs.we   = mem_we;
    if (show_addr) obs.addr = mem_addr;
    if (w >= 0)    obs.wd   = mem_wd;
    obs.v0   = p0_rsp_valid;
    obs.v1   = p1_rsp_valid;
    if (exp_v.v0) begin obs.e0 = p0_rsp_err; obs.d0 = p0_rsp_rdata; end
    if (exp_v.v1) begin obs.e1 = p1_rsp_err; obs.d1 = p1_rsp_rdata; end
    obs.busy = busy;

    @(posedge clk);
    #1;
    if (rst) begin
      pend_v = 0; m_ptr = 0; last_known = 0;
    end else begin
      pend_v = (w >= 0);
      if (w >= 0) begin
        pend_owner = (w == 1);
        pend_err   = !legal(wa);
        pend_data  = (!wwe && legal(wa)) ? model_mem[int'(wa >> 2)] : '0;
        if (wwe && legal(wa)) model_mem[int'(wa >> 2)] = wd;
        last_known = 1;
        last_addr  = AW'(wa >> 2);
        if (v0 && v1) m_ptr = !m_ptr;
      end
    end
    gnt_port = w;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      run_cycle(1, 1, 1, rand_addr(), $urandom(), 1, 1, rand_addr(), $urandom());
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset[%0d]: got %h expected %h", i, obs, exp_v); end
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_zero[%0d]: got %h expected 0", i, obs); end
    end
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_store_load();
    run_cycle(0, 0, 0, 0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL store_load.store: got %h expected %h", obs, exp_v); end
    run_cycle(0, 0, 0, 0, 0, 1, 0, 32'h10, 32'h0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL store_load.load: got %h expected %h", obs, exp_v); end
    checks++;
    if ({obs.v1, obs.e1, obs.d1} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL store_load.store_rsp: got v=%0b e=%0b d=%h expected v=1 e=0 d=0", obs.v1, obs.e1, obs.d1);
    end
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL store_load.rsp: got %h expected %h", obs, exp_v); end
    checks++;
    if (obs.d1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_load.rdata: got %h expected deadbeef", obs.d1); end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 6; i++) begin
      run_cycle(0, 1, 0, 32'($urandom_range(0, WORDS - 1)) << 2, $urandom(),
                   1, 0, 32'($urandom_range(0, WORDS - 1)) << 2, $urandom());
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL round_robin[%0d]: got %h expected %h", i, obs, exp_v); end
      checks++;
      if ({obs.r0, obs.r1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL round_robin_order[%0d]: got r0=%0b r1=%0b", i, obs.r0, obs.r1);
      end
    end
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL round_robin.tail: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_fixed_priority();
    logic [31:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 7; i++) begin
      a = 32'($urandom_range(0, WORDS - 1)) << 2;
      d = $urandom();
      fp_p0_req_valid = (i < 6); fp_p0_req_we = 0; fp_p0_req_addr = a; fp_p0_req_wdata = d;
      fp_p1_req_valid = (i < 6); fp_p1_req_we = 0; fp_p1_req_addr = rand_addr(); fp_p1_req_wdata = $urandom();
      @(negedge clk);
      checks++;
      if ({fp_p0_req_ready, fp_p1_req_ready, fp_mem_we, fp_p1_rsp_valid, fp_p0_rsp_valid, fp_busy}
          !== {i < 6, 1'b0, 1'b0, 1'b0, i > 0, i > 0}) begin
        errors++;
        $display("FAIL fixed_prio[%0d]: got r0=%0b r1=%0b we=%0b v1=%0b v0=%0b busy=%0b", i,
                 fp_p0_req_ready, fp_p1_req_ready, fp_mem_we, fp_p1_rsp_valid, fp_p0_rsp_valid, fp_busy);
      end
      if (i < 6) begin
        checks++;
        if ({fp_mem_addr, fp_mem_wd} !== {AW'(a >> 2), d}) begin
          errors++; $display("FAIL fixed_prio_mem[%0d]: got %h/%h expected %h/%h", i, fp_mem_addr, fp_mem_wd, AW'(a >> 2), d);
        end
      end
      if (i > 0) begin
        checks++;
        if ({fp_p0_rsp_err, fp_p0_rsp_rdata} !== {1'b0, FP_RD}) begin
          errors++; $display("FAIL fixed_prio_rsp[%0d]: got err=%0b d=%h expected err=0 d=%h", i, fp_p0_rsp_err, fp_p0_rsp_rdata, FP_RD);
        end
      end
      @(posedge clk);
      #1;
    end
    fp_p0_req_valid = 0;
    fp_p1_req_valid = 0;
  endtask

  task automatic test_illegal();
    run_cycle(0, 1, 1, 32'h0000_0802, $urandom(), 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL illegal.misaligned: got %h expected %h", obs, exp_v); end
    checks++;
    if (obs.we !== 1'b0) begin errors++; $display("FAIL illegal.misaligned_we: got %0b expected 0", obs.we); end
    run_cycle(0, 1, 1, 32'h0000_0800, $urandom(), 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL illegal.range: got %h expected %h", obs, exp_v); end
    checks++;
    if ({obs.we, obs.v0, obs.e0, obs.d0} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL illegal.range_we_rsp: got we=%0b v=%0b e=%0b d=%h", obs.we, obs.v0, obs.e0, obs.d0);
    end
    run_cycle(0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL illegal.load0: got %h expected %h", obs, exp_v); end
    checks++;
    if ({obs.v0, obs.e0} !== 2'b11) begin errors++; $display("FAIL illegal.range_err: got v=%0b e=%0b expected 1 1", obs.v0, obs.e0); end
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL illegal.word0: got %h expected %h", obs, exp_v); end
    checks++;
    if (obs.d0 !== init_word(0)) begin errors++; $display("FAIL illegal.word0_kept: got %h expected %h", obs.d0, init_word(0)); end
  endtask

  task automatic test_back_to_back_raw();
    run_cycle(0, 1, 1, 32'h20, 32'h1234, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL raw.store: got %h expected %h", obs, exp_v); end
    run_cycle(0, 1, 0, 32'h20, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL raw.load: got %h expected %h", obs, exp_v); end
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL raw.rsp: got %h expected %h", obs, exp_v); end
    checks++;
    if (obs.d0 !== 32'h1234) begin errors++; $display("FAIL raw.rdata: got %h expected 1234", obs.d0); end
  endtask

  task automatic test_reset_midstream();
    run_cycle(0, 1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_reset.tie: got %h expected %h", obs, exp_v); end
    run_cycle(0, 0, 0, 0, 0, 1, 0, 32'h48, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_reset.load: got %h expected %h", obs, exp_v); end
    run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_reset.in_reset: got %h expected %h", obs, exp_v); end
    checks++;
    if ({obs.v0, obs.v1, obs.busy} !== 3'b000) begin
      errors++; $display("FAIL mid_reset.dropped: got v0=%0b v1=%0b busy=%0b expected 0", obs.v0, obs.v1, obs.busy);
    end
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL mid_reset.after: got %h expected 0", obs); end
    run_cycle(0, 1, 0, 32'h4C, 0, 1, 0, 32'h50, 0);
    checks++;
    if ({obs.r0, obs.r1} !== 2'b10) begin errors++; $display("FAIL mid_reset.ptr: got r0=%0b r1=%0b expected 1 0", obs.r0, obs.r1); end
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_reset.tail: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_random();
    logic hv0, hwe0, hv1, hwe1, rst;
    logic [31:0] ha0, ha1;
    logic [DW-1:0] hd0, hd1;
    hv0 = 0; hwe0 = 0; ha0 = 0; hd0 = 0;
    hv1 = 0; hwe1 = 0; ha1 = 0; hd1 = 0;
    for (int i = 0; i < 400; i++) begin
      // A waiting requester keeps its request stable until granted.
      if (!(hv0 && gnt_port != 0)) begin
        hv0 = ($urandom_range(0, 99) < 60); hwe0 = 1'($urandom_range(0, 1)); ha0 = rand_addr(); hd0 = $urandom();
      end
      if (!(hv1 && gnt_port != 1)) begin
        hv1 = ($urandom_range(0, 99) < 60); hwe1 = 1'($urandom_range(0, 1)); ha1 = rand_addr(); hd1 = $urandom();
      end
      rst = ($urandom_range(0, 99) < 2);
      run_cycle(rst, hv0, hwe0, ha0, hd0, hv1, hwe1, ha1, hd1);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_v); end
    end
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL random.tail: got %h expected %h", obs, exp_v); end
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    checks = 0; errors = 0;
    m_ptr = 0; pend_v = 0; pend_owner = 0; pend_err = 0; pend_data = '0;
    last_known = 0; last_addr = '0; gnt_port = -1;
    for (int i = 0; i < WORDS; i++) model_mem[i] = init_word(i);
    ram_fill = 1;
    reset = 1;
    p0_req_valid = 0; p0_req_we = 0; p0_req_addr = 0; p0_req_wdata = 0;
    p1_req_valid = 0; p1_req_we = 0; p1_req_addr = 0; p1_req_wdata = 0;
    fp_p0_req_valid = 0; fp_p0_req_we = 0; fp_p0_req_addr = 0; fp_p0_req_wdata = 0;
    fp_p1_req_valid = 0; fp_p1_req_we = 0; fp_p1_req_addr = 0; fp_p1_req_wdata = 0;
    @(posedge clk);
    #1;
    ram_fill = 0;

    test_reset();
    test_store_load();
    test_round_robin();
    test_fixed_priority();
    test_illegal();
    test_back_to_back_raw();
    test_reset_midstream();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
